// File: rtl/signed_seq_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor. Each cycle the
// restoring loop produces one magnitude quotient bit. A final cycle then
// applies the signs: the quotient truncates toward zero and the remainder
// takes the sign of the dividend.
module signed_seq_divider #(
    parameter int unsigned N_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   start,
    input  logic [2*N_WIDTH-1:0]   op_1,
    input  logic [N_WIDTH-1:0]     op_2,
    output logic [2*N_WIDTH-1:0]   o_quotient,
    output logic [N_WIDTH-1:0]     o_remainder,
    output logic                   o_done,
    output logic                   o_busy,
    output logic                   o_dbz,
    output logic                   o_ovf
);

    localparam int unsigned NW = N_WIDTH;
    localparam int unsigned QW = 2 * N_WIDTH;
    localparam int unsigned CW = (QW > 2) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [QW-1:0]   qmag;
    logic [NW:0]     pr;
    logic [NW-1:0]   dmag;
    logic [CW-1:0]   cnt;
    logic            sign_q;
    logic            sign_r;
    logic            dbz;
    logic            ovf;

    logic [QW-1:0]   op1_mag;
    logic [NW-1:0]   op2_mag;
    logic            op1_min;
    logic            op2_neg1;
    logic            op2_zero;
    logic [NW+1:0]   shifted;
    logic [NW+1:0]   trial;
    logic [QW-1:0]   q_neg;
    logic [NW-1:0]   r_mag;
    logic [NW-1:0]   r_neg;

    // Operand magnitudes; the most negative value maps onto its unsigned magnitude
    assign op1_mag  = op_1[QW-1] ? (~op_1 + QW'(1)) : op_1;
    assign op2_mag  = op_2[NW-1] ? (~op_2 + NW'(1)) : op_2;
    assign op1_min  = (op_1 == {1'b1, {(QW-1){1'b0}}});
    assign op2_neg1 = (op_2 == {NW{1'b1}});
    assign op2_zero = (op_2 == {NW{1'b0}});

    // One restoring step: shift the next dividend bit into the partial remainder,
    // then try to subtract the divisor magnitude (the MSB of trial is the borrow)
    assign shifted  = {pr, qmag[QW-1]};
    assign trial    = shifted - {2'b00, dmag};

    // Sign-corrected result candidates
    assign q_neg    = ~qmag + QW'(1);
    assign r_mag    = pr[NW-1:0];
    assign r_neg    = ~r_mag + NW'(1);

    // Controller and datapath: accept, iterate, fix signs, pulse done
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            qmag        <= '0;
            pr          <= '0;
            dmag        <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz         <= 1'b0;
            ovf         <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
            o_dbz       <= 1'b0;
            o_ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        qmag   <= op1_mag;
                        dmag   <= op2_mag;
                        sign_q <= op_1[QW-1] ^ op_2[NW-1];
                        sign_r <= op_1[QW-1];
                        dbz    <= op2_zero;
                        ovf    <= op1_min & op2_neg1;
                        pr     <= '0;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    if (!trial[NW+1]) begin
                        pr   <= trial[NW:0];
                        qmag <= {qmag[QW-2:0], 1'b1};
                    end else begin
                        pr   <= shifted[NW:0];
                        qmag <= {qmag[QW-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(QW - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // A zero divisor still runs the full loop, but its result is forced to zero
                    if (dbz) begin
                        o_quotient  <= '0;
                        o_remainder <= '0;
                    end else begin
                        o_quotient  <= sign_q ? q_neg : qmag;
                        o_remainder <= sign_r ? r_neg : r_mag;
                    end
                    o_dbz  <= dbz;
                    o_ovf  <= ovf;
                    o_done <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Bench for signed_seq_divider (N_WIDTH=4). A cycle-count reference model built
// on plain integer division is compared against the DUT on every cycle. Directed
// vectors carry hand-computed literal results.
module tb_signed_seq_divider;

    localparam int unsigned NW  = 4;
    localparam int unsigned QW  = 8;
    localparam int          LAT = 10;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        logic       ovf;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  op_1;
    logic [3:0]  op_2;
    logic [7:0]  o_quotient;
    logic [3:0]  o_remainder;
    logic        o_done;
    logic        o_busy;
    logic        o_dbz;
    logic        o_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    signed_seq_divider #(.N_WIDTH(NW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .start       (start),
        .op_1        (op_1),
        .op_2        (op_2),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_dbz       (o_dbz),
        .o_ovf       (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report it if it failed
    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference for one division
    function automatic res_t model(input logic [7:0] a, input logic [3:0] b);
        res_t res;
        int   ai;
        int   bi;
        ai  = int'($signed(a));
        bi  = int'($signed(b));
        res = '0;
        if (bi == 0) begin
            res.dbz = 1'b1;
        end else begin
            res.q   = 8'(ai / bi);
            res.r   = 4'(ai % bi);
            res.ovf = (ai == -128) && (bi == -1);
        end
        return res;
    endfunction

    // Timing model: after an accepted start the result appears LAT cycles later
    int   m_cnt;
    res_t m_pend;
    res_t m_res;
    logic m_busy;
    logic m_done;

    assign m_busy = (m_cnt != 0);
    assign m_done = (m_cnt == LAT);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_pend <= '0;
            m_res  <= '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  <= 1;
                m_pend <= model(op_1, op_2);
            end
        end else if (m_cnt == LAT - 1) begin
            m_res <= m_pend;
            m_cnt <= LAT;
        end else if (m_cnt == LAT) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Check every DUT output against the model on every falling edge
    always @(negedge clk) begin
        chk({o_quotient, o_remainder, o_dbz, o_ovf, o_done, o_busy} === {m_res, m_done, m_busy},
            "cycle {q,r,dbz,ovf,done,busy}",
            64'({o_quotient, o_remainder, o_dbz, o_ovf, o_done, o_busy}),
            64'({m_res, m_done, m_busy}));
    end

    // Issue one operation, scramble the operands while busy, then wait for done
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit lit,
                          input logic [7:0] eq, input logic [3:0] er,
                          input bit edbz, input bit eovf, input string name);
        int k;
        bit seen;
        int ai;
        int bi;
        int qi;
        int ri;
        k = 0;
        while (o_busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (o_busy) chk(1'b0, {name, " idle wait"}, 64'(1), 64'(0));
        start = 1'b1;
        op_1  = a;
        op_2  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_1  = 8'($urandom);
        op_2  = 4'($urandom);
        k     = 1;
        seen  = 1'b0;
        while (!seen && k <= 30) begin
            if (o_done) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        if (!seen) begin
            chk(1'b0, {name, " done timeout"}, 64'(k), 64'(LAT));
        end else begin
            chk(k == LAT, {name, " latency"}, 64'(k), 64'(LAT));
            if (lit) begin
                chk(o_quotient == eq, {name, " quotient"}, 64'(o_quotient), 64'(eq));
                chk(o_remainder == er, {name, " remainder"}, 64'(o_remainder), 64'(er));
                chk({o_dbz, o_ovf} == {edbz, eovf}, {name, " {dbz,ovf}"},
                    64'({o_dbz, o_ovf}), 64'({edbz, eovf}));
            end else begin
                ai = int'($signed(a));
                bi = int'($signed(b));
                qi = int'($signed(o_quotient));
                ri = int'($signed(o_remainder));
                if (bi != 0 && !(ai == -128 && bi == -1)) begin
                    chk((qi * bi + ri == ai) && ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi))
                        && (ri == 0 || ((ri < 0) == (ai < 0))),
                        {name, " identity q*d+r"}, 64'({a, b}), 64'({o_quotient, o_remainder}));
                end
            end
        end
    endtask

    int k;
    int gap;
    bit stop_sweep;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_1  = '0;
        op_2  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk({o_quotient, o_remainder, o_done, o_busy, o_dbz, o_ovf} == 16'h0, "reset outputs",
            64'({o_quotient, o_remainder, o_done, o_busy, o_dbz, o_ovf}), 64'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk(o_busy == 1'b0, "idle busy", 64'(o_busy), 64'(0));

        // Sign quadrants
        run_op(8'd100,  4'd7,  1'b1, 8'h0E, 4'h2, 1'b0, 1'b0, "100/7");
        run_op(8'h9C,   4'd7,  1'b1, 8'hF2, 4'hE, 1'b0, 1'b0, "-100/7");
        run_op(8'd100,  4'h9,  1'b1, 8'hF2, 4'h2, 1'b0, 1'b0, "100/-7");
        run_op(8'h9C,   4'h9,  1'b1, 8'h0E, 4'hE, 1'b0, 1'b0, "-100/-7");

        // Extremes
        run_op(8'd127,  4'h8,  1'b1, 8'hF1, 4'h7, 1'b0, 1'b0, "127/-8");
        run_op(8'h80,   4'h1,  1'b1, 8'h80, 4'h0, 1'b0, 1'b0, "-128/1");
        run_op(8'h80,   4'hF,  1'b1, 8'h80, 4'h0, 1'b0, 1'b1, "-128/-1");

        // Divide by zero, then a clean op clears the flag
        run_op(8'd55,   4'h0,  1'b1, 8'h00, 4'h0, 1'b1, 1'b0, "55/0");
        run_op(8'd9,    4'h3,  1'b1, 8'h03, 4'h0, 1'b0, 1'b0, "9/3");

        // start held high: accepted only every LAT+1 edges
        @(negedge clk);
        start = 1'b1;
        op_1  = 8'd100;
        op_2  = 4'd7;
        k = 0;
        while (!o_done && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk(o_done == 1'b1, "held start first done", 64'(o_done), 64'(1));
        @(negedge clk);
        gap = 1;
        while (!o_done && gap < 30) begin
            @(negedge clk);
            gap++;
        end
        chk(gap == LAT + 1, "held start done spacing", 64'(gap), 64'(LAT + 1));
        chk(o_quotient == 8'h0E, "held start quotient", 64'(o_quotient), 64'(8'h0E));
        start = 1'b0;

        // Reset in the middle of an operation
        k = 0;
        while (o_busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        op_1  = 8'd100;
        op_2  = 4'd7;
        @(posedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk({o_quotient, o_remainder, o_done, o_busy, o_dbz, o_ovf} == 16'h0, "mid-op reset outputs",
            64'({o_quotient, o_remainder, o_done, o_busy, o_dbz, o_ovf}), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk(o_done == 1'b0 && o_quotient == 8'h0, "aborted result absent",
            64'({o_done, o_quotient}), 64'(0));
        run_op(8'd20,   4'd3,  1'b1, 8'h06, 4'h2, 1'b0, 1'b0, "20/3");

        // Every operand pair
        stop_sweep = 1'b0;
        for (int a = 0; a < 256 && !stop_sweep; a++) begin
            for (int b = 0; b < 16 && !stop_sweep; b++) begin
                run_op(8'(a), 4'(b), 1'b0, 8'h0, 4'h0, 1'b0, 1'b0, "sweep");
                if (n_bad > 50) stop_sweep = 1'b1;
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
